multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore FSM that sequences a shared-memory, multicycle variant of the dmips datapath: one ALU, one memory port for instructions and data, one IR, and an ALUOut register.
- Supports the existing ISA subset: R-type (add/sub/and/or/slt), addi, lb, sb, beq, j.
- Memory accesses use a ready handshake, so variable-latency memory is supported.
- Sits between the IR op/funct fields and the datapath mux selects and write enables.

Parameters:
- MEMWAIT_MAX, 15: maximum wait cycles allowed in any memory state before the timeout error; 0 disables the timeout.
- WAITW, 4: width of the wait counter; must satisfy 2^WAITW > MEMWAIT_MAX.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- pcen  out  1  PC write enable: pcwrite OR (branch AND zero).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread, memwrite  out  1  memory request strobes.
- irwrite  out  1  IR load.
- regdst, memtoreg, regwrite  out  1  register file controls.
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B select: 00 = rt, 01 = 4, 10 = signext, 11 = signext<<2.
- pcsrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- alucont  out  3  ALU op code.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- mem_err  out  1  sticky memory timeout flag.
- state_o  out  4  current state, for debug.

Behaviour:
- State encoding (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, HALT=12.
- Reset: state=FETCH, wait counter=0, mem_err=0.
- While reset is high, all enables (pcen, memread, memwrite, irwrite, regwrite, instr_done) are forced to 0.
- Outputs decode from the current state only, plus mem_ready gating. Every output not listed for a state is 0.
- FETCH:
  - memread=1, iord=0, alusrca=0, alusrcb=01, alucont=010.
  - pcen and irwrite assert only in a cycle where mem_ready=1.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - alusrca=0, alusrcb=11, alucont=010 (branch target into ALUOut).
  - Next state by op: 000000 -> RTYPEEX; 001000 -> ADDIEX; 100000/101000 -> MEMADR; 000100 -> BEQEX; 000010 -> JEX; other -> see Optional Feature.
- MEMADR: alusrca=1, alusrcb=10, alucont=010. Next state: MEMRD if op=lb, else MEMWR.
- MEMRD: memread=1, iord=1. Holds until mem_ready, then MEMWB.
- MEMWB: memtoreg=1, regwrite=1, regdst=0. Then FETCH.
- MEMWR: memwrite=1, iord=1. Holds until mem_ready, then FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, alucont from funct. Then RTYPEWB.
- funct decode for alucont: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->101 (no-op).
- RTYPEWB: regdst=1, regwrite=1. Then FETCH.
- BEQEX: alusrca=1, alusrcb=00, alucont=110, pcsrc=01, pcen=zero. Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alucont=010. Then ADDIWB.
- ADDIWB: regwrite=1, regdst=0. Then FETCH.
- JEX: pcsrc=10, pcen=1. Then FETCH.
- instr_done is high in the final cycle of each instruction: MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX, and the cycle of MEMWR where mem_ready=1.
- Memory request stability: memread/memwrite and iord stay asserted and stable from state entry until the mem_ready cycle inclusive.
- A mem_ready seen outside FETCH, MEMRD and MEMWR is ignored.
- Wait counter:
  - Clears on entry to FETCH, MEMRD and MEMWR, and whenever mem_ready=1.
  - Increments each cycle spent in one of those states with mem_ready=0.
  - Saturates at MEMWAIT_MAX.
- Timeout: when MEMWAIT_MAX≠0, the counter equals MEMWAIT_MAX, and mem_ready=0, the next state is HALT and mem_err is set.
- HALT: all outputs 0 except mem_err. Left only by reset.
- A reset asserted mid-instruction aborts it; the next cycle is FETCH with no writes issued.

Optional Feature:
- Macro MC_ILLOP_TRAP_EN.
- Defined:
  - An unknown op in DECODE goes to HALT.
  - Adds output illop (1 bit), sticky, cleared by reset.
  - An undefined funct in RTYPEEX also traps, instead of continuing to RTYPEWB.
- Undefined:
  - An unknown op goes from DECODE straight to FETCH as a NOP with instr_done=1.
  - The illop port is absent.

Decomposition:
- Package mc_pkg holds:
  - state enum/localparams;
  - opcode constants (RTYPE, ADDI, LB, SB, BEQ, J);
  - funct constants;
  - ALU codes (ADD=010, SUB=110, AND=000, OR=001, SLT=111, NOP=101);
  - alusrcb and pcsrc encodings.
- One sub-module, mc_alu_decode: combinational {aluop, funct} -> alucont.
- The FSM, wait counter and output decode live in the top module.

Test Plan:
- add with mem_ready tied high: FETCH,DECODE,RTYPEEX,RTYPEWB = 4 cycles. RTYPEWB has regdst=1, regwrite=1; alucont=010 in RTYPEEX; instr_done pulses once.
- lb with mem_ready delayed 3 cycles in both FETCH and MEMRD: each state holds 3 extra cycles with memread=1 stable. irwrite/pcen assert only on the ready cycle. Total 5+6=11 cycles.
- beq with zero=1 vs zero=0: pcen=1 vs 0 in BEQEX; pcsrc=01 and alucont=110 in both cases.
- j: DECODE->JEX, pcen=1, pcsrc=10, back to FETCH after 3 cycles. sb: memwrite=1, iord=1 in MEMWR, regwrite never asserts.
- MEMWAIT_MAX=15 with mem_ready held low in FETCH: HALT after 16 FETCH cycles, mem_err=1 stays set. Reset clears it and the state returns to FETCH.
- Reset pulsed during MEMRD: next cycle state_o=0 and no regwrite. Op 111111 gives a NOP/FETCH without the macro, and HALT with illop=1 with MC_ILLOP_TRAP_EN.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle controller: FSM states, ISA opcode/funct
// fields, ALU codes and datapath mux encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_HALT    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOP = 3'b101;

    // ALU_NONE drives alucont to 000 in states that do not use the ALU.
    typedef enum logic [1:0] {
        ALUOP_NONE  = 2'b00,
        ALUOP_ADD   = 2'b01,
        ALUOP_SUB   = 2'b10,
        ALUOP_FUNCT = 2'b11
    } aluop_e;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU control: maps the FSM's ALU request and the R-type funct field to the
// 3-bit alucont code. An undefined funct yields ALU_NOP.
module mc_alu_decode
    import mc_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucont_o
);

    always_comb begin
        alucont_o = 3'b000;
        case (aluop_i)
            ALUOP_ADD: alucont_o = ALU_ADD;
            ALUOP_SUB: alucont_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alucont_o = ALU_ADD;
                    FUNCT_SUB: alucont_o = ALU_SUB;
                    FUNCT_AND: alucont_o = ALU_AND;
                    FUNCT_OR:  alucont_o = ALU_OR;
                    FUNCT_SLT: alucont_o = ALU_SLT;
                    default:   alucont_o = ALU_NOP;
                endcase
            end
            default: alucont_o = 3'b000;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore controller for the shared-memory multicycle datapath with ready-handshaked memory and
// a memory-wait timeout. Define MC_ILLOP_TRAP_EN to trap unknown opcodes/functs into HALT.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int MEMWAIT_MAX = 15,
    parameter int WAITW       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucont,
    output logic       instr_done,
    output logic       mem_err,
`ifdef MC_ILLOP_TRAP_EN
    output logic       illop,
`endif
    output logic [3:0] state_o
);

    state_e           state_q, state_d;
    logic [WAITW-1:0] wait_q, wait_d;
    logic             mem_err_q, mem_err_d;
`ifdef MC_ILLOP_TRAP_EN
    logic             illop_q, illop_d;
`endif

    aluop_e aluop;
    logic   op_known, timeout;
    logic   pcwrite_raw, branch_raw, memread_raw, memwrite_raw;
    logic   irwrite_raw, regwrite_raw, done_raw;

    assign op_known = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LB) ||
                      (op == OP_SB) || (op == OP_BEQ) || (op == OP_J);

    assign timeout = (MEMWAIT_MAX != 0) && is_mem_state(state_q) && !mem_ready &&
                     (wait_q == WAITW'(MEMWAIT_MAX));

    mc_alu_decode u_alu_decode (
        .aluop_i   (aluop),
        .funct_i   (funct),
        .alucont_o (alucont)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
`ifdef MC_ILLOP_TRAP_EN
            illop_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
`ifdef MC_ILLOP_TRAP_EN
            illop_q   <= illop_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_err_d = mem_err_q;
`ifdef MC_ILLOP_TRAP_EN
        illop_d   = illop_q;
`endif
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:      state_d = S_RTYPEEX;
                    OP_ADDI:       state_d = S_ADDIEX;
                    OP_LB, OP_SB:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BEQEX;
                    OP_J:          state_d = S_JEX;
                    default: begin
`ifdef MC_ILLOP_TRAP_EN
                        state_d = S_HALT;
                        illop_d = 1'b1;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LB) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_RTYPEEX: begin
                state_d = S_RTYPEWB;
`ifdef MC_ILLOP_TRAP_EN
                // The decoder returns ALU_NOP only for an undefined funct.
                if (alucont == ALU_NOP) begin
                    state_d = S_HALT;
                    illop_d = 1'b1;
                end
`endif
            end
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX: state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
        if (timeout) begin
            state_d   = S_HALT;
            mem_err_d = 1'b1;
        end
    end

    // Counts stalled cycles of the current memory access; any state change restarts it.
    always_comb begin
        wait_d = wait_q;
        if (!is_mem_state(state_q) || mem_ready || (state_d != state_q)) begin
            wait_d = '0;
        end else if (wait_q != WAITW'(MEMWAIT_MAX)) begin
            wait_d = wait_q + WAITW'(1);
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pcwrite_raw  = 1'b0;
        branch_raw   = 1'b0;
        memread_raw  = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        done_raw     = 1'b0;
        iord         = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = SRCB_RT;
        pcsrc        = PCSRC_ALU;
        aluop        = ALUOP_NONE;
        case (state_q)
            S_FETCH: begin
                memread_raw = 1'b1;
                alusrcb     = SRCB_FOUR;
                aluop       = ALUOP_ADD;
                pcwrite_raw = mem_ready;
                irwrite_raw = mem_ready;
            end
            S_DECODE: begin
                alusrcb = SRCB_BRANCH;
                aluop   = ALUOP_ADD;
`ifndef MC_ILLOP_TRAP_EN
                done_raw = !op_known;
`endif
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                memread_raw = 1'b1;
                iord        = 1'b1;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_MEMWR: begin
                memwrite_raw = 1'b1;
                iord         = 1'b1;
                done_raw     = mem_ready;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = PCSRC_ALUOUT;
                branch_raw = 1'b1;
                done_raw   = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
                done_raw     = 1'b1;
            end
            S_JEX: begin
                pcsrc       = PCSRC_JUMP;
                pcwrite_raw = 1'b1;
                done_raw    = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset is synchronous, so the enables are masked while it is high to abort cleanly.
    assign pcen       = (pcwrite_raw | (branch_raw & zero)) & ~reset;
    assign memread    = memread_raw  & ~reset;
    assign memwrite   = memwrite_raw & ~reset;
    assign irwrite    = irwrite_raw  & ~reset;
    assign regwrite   = regwrite_raw & ~reset;
    assign instr_done = done_raw     & ~reset;
    assign mem_err    = mem_err_q;
    assign state_o    = state_q;
`ifdef MC_ILLOP_TRAP_EN
    assign illop      = illop_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a per-cycle vector table plus hand-written
// reset/timeout sequences, with expected outputs queued as stimulus is driven.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcen, iord, memread, memwrite, irwrite;
        logic       regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alucont;
        logic       instr_done, mem_err;
        logic [3:0] state;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [5:0] op, funct;
        logic       zero, rdy;
        outs_t      exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, zero, mem_ready;
    logic [5:0] op, funct;
    logic       pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucont;
    logic       instr_done, mem_err;
    logic [3:0] state_o;
`ifdef MC_ILLOP_TRAP_EN
    logic       illop;
`endif

    multicycle_controller #(.MEMWAIT_MAX(15), .WAITW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcen       (pcen),
        .iord       (iord),
        .memread    (memread),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucont    (alucont),
        .instr_done (instr_done),
        .mem_err    (mem_err),
`ifdef MC_ILLOP_TRAP_EN
        .illop      (illop),
`endif
        .state_o    (state_o)
    );

    localparam logic [5:0] RT = 6'b000000, ADDI = 6'b001000, LB = 6'b100000;
    localparam logic [5:0] SB = 6'b101000, BEQ = 6'b000100, JMP = 6'b000010, BAD = 6'b111111;

    int    checks = 0;
    int    errors = 0;
    vec_t  vecs[$];
    outs_t sb_q[$];

    function automatic outs_t mk(input logic [3:0] st, input logic pe, io, mr, mw, ir,
                                 input logic rd, mtr, rw, sa, input logic [1:0] sb, ps,
                                 input logic [2:0] ac, input logic dn, err);
        outs_t o;
        o.state = st;   o.pcen = pe;     o.iord = io;      o.memread = mr;  o.memwrite = mw;
        o.irwrite = ir; o.regdst = rd;   o.memtoreg = mtr; o.regwrite = rw; o.alusrca = sa;
        o.alusrcb = sb; o.pcsrc = ps;    o.alucont = ac;   o.instr_done = dn; o.mem_err = err;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.state = state_o;     o.pcen = pcen;         o.iord = iord;         o.memread = memread;
        o.memwrite = memwrite; o.irwrite = irwrite;   o.regdst = regdst;     o.memtoreg = memtoreg;
        o.regwrite = regwrite; o.alusrca = alusrca;   o.alusrcb = alusrcb;   o.pcsrc = pcsrc;
        o.alucont = alucont;   o.instr_done = instr_done; o.mem_err = mem_err;
        return o;
    endfunction

    // Expected output bundles, one per state flavour.
    outs_t E_RST, E_FW, E_FR, E_DEC, E_DNOP, E_MA, E_MRD, E_MRD_RST, E_MWB;
    outs_t E_MWW, E_MWR, E_RWB, E_AEX, E_AWB, E_JEX, E_HALT_ERR;

    function automatic outs_t rex(input logic [2:0] ac);
        return mk(4'd6, 0,0,0,0,0, 0,0,0,1, 2'b00, 2'b00, ac, 0, 0);
    endfunction

    function automatic outs_t beqx(input logic z);
        return mk(4'd8, z,0,0,0,0, 0,0,0,1, 2'b00, 2'b01, 3'b110, 1, 0);
    endfunction

    task automatic check(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                     name, act, act.state, exp, exp.state);
        end
    endtask

    task automatic step(input logic rst, input logic [5:0] o, f, input logic z, r,
                        input outs_t exp, input string name);
        outs_t e;
        reset = rst; op = o; funct = f; zero = z; mem_ready = r;
        sb_q.push_back(exp);
        @(negedge clk);
        e = sb_q.pop_front();
        check(name, sample(), e);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rst, input logic [5:0] o, f, input logic z, r, input outs_t e);
        vec_t v;
        v.rst = rst; v.op = o; v.funct = f; v.zero = z; v.rdy = r; v.exp = e;
        vecs.push_back(v);
    endtask

    logic [5:0] fn_tab[6];
    logic [2:0] ac_tab[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        E_RST      = mk(4'd0,  0,0,0,0,0, 0,0,0,0, 2'b01, 2'b00, 3'b010, 0, 0);
        E_FW       = mk(4'd0,  0,0,1,0,0, 0,0,0,0, 2'b01, 2'b00, 3'b010, 0, 0);
        E_FR       = mk(4'd0,  1,0,1,0,1, 0,0,0,0, 2'b01, 2'b00, 3'b010, 0, 0);
        E_DEC      = mk(4'd1,  0,0,0,0,0, 0,0,0,0, 2'b11, 2'b00, 3'b010, 0, 0);
        E_DNOP     = mk(4'd1,  0,0,0,0,0, 0,0,0,0, 2'b11, 2'b00, 3'b010, 1, 0);
        E_MA       = mk(4'd2,  0,0,0,0,0, 0,0,0,1, 2'b10, 2'b00, 3'b010, 0, 0);
        E_MRD      = mk(4'd3,  0,1,1,0,0, 0,0,0,0, 2'b00, 2'b00, 3'b000, 0, 0);
        E_MRD_RST  = mk(4'd3,  0,1,0,0,0, 0,0,0,0, 2'b00, 2'b00, 3'b000, 0, 0);
        E_MWB      = mk(4'd4,  0,0,0,0,0, 0,1,1,0, 2'b00, 2'b00, 3'b000, 1, 0);
        E_MWW      = mk(4'd5,  0,1,0,1,0, 0,0,0,0, 2'b00, 2'b00, 3'b000, 0, 0);
        E_MWR      = mk(4'd5,  0,1,0,1,0, 0,0,0,0, 2'b00, 2'b00, 3'b000, 1, 0);
        E_RWB      = mk(4'd7,  0,0,0,0,0, 1,0,1,0, 2'b00, 2'b00, 3'b000, 1, 0);
        E_AEX      = mk(4'd9,  0,0,0,0,0, 0,0,0,1, 2'b10, 2'b00, 3'b010, 0, 0);
        E_AWB      = mk(4'd10, 0,0,0,0,0, 0,0,1,0, 2'b00, 2'b00, 3'b000, 1, 0);
        E_JEX      = mk(4'd11, 1,0,0,0,0, 0,0,0,0, 2'b00, 2'b10, 3'b000, 1, 0);
        E_HALT_ERR = mk(4'd12, 0,0,0,0,0, 0,0,0,0, 2'b00, 2'b00, 3'b000, 0, 1);

        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        ac_tab = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b101};

        // R-type, every funct including an undefined one (NOP through to writeback)
`ifdef MC_ILLOP_TRAP_EN
        for (int i = 0; i < 5; i++) begin
`else
        for (int i = 0; i < 6; i++) begin
`endif
            add(0, RT, fn_tab[i], 1, 1, E_FR);
            add(0, RT, fn_tab[i], 1, 1, E_DEC);
            add(0, RT, fn_tab[i], 1, 1, rex(ac_tab[i]));
            add(0, RT, fn_tab[i], 1, 1, E_RWB);
        end
        // lb with three stall cycles in FETCH and in MEMRD
        for (int i = 0; i < 3; i++) add(0, LB, 6'h00, 0, 0, E_FW);
        add(0, LB, 6'h00, 0, 1, E_FR);
        add(0, LB, 6'h00, 0, 1, E_DEC);
        add(0, LB, 6'h00, 0, 1, E_MA);
        for (int i = 0; i < 3; i++) add(0, LB, 6'h00, 0, 0, E_MRD);
        add(0, LB, 6'h00, 0, 1, E_MRD);
        add(0, LB, 6'h00, 0, 1, E_MWB);
        // sb with one stall in MEMWR
        add(0, SB, 6'h00, 0, 1, E_FR);
        add(0, SB, 6'h00, 0, 1, E_DEC);
        add(0, SB, 6'h00, 0, 1, E_MA);
        add(0, SB, 6'h00, 0, 0, E_MWW);
        add(0, SB, 6'h00, 0, 1, E_MWR);
        // beq taken / not taken
        add(0, BEQ, 6'h00, 1, 1, E_FR);
        add(0, BEQ, 6'h00, 1, 1, E_DEC);
        add(0, BEQ, 6'h00, 1, 1, beqx(1'b1));
        add(0, BEQ, 6'h00, 0, 1, E_FR);
        add(0, BEQ, 6'h00, 0, 1, E_DEC);
        add(0, BEQ, 6'h00, 0, 1, beqx(1'b0));
        // addi and j
        add(0, ADDI, 6'h00, 0, 1, E_FR);
        add(0, ADDI, 6'h00, 0, 1, E_DEC);
        add(0, ADDI, 6'h00, 0, 1, E_AEX);
        add(0, ADDI, 6'h00, 0, 1, E_AWB);
        add(0, JMP, 6'h00, 0, 1, E_FR);
        add(0, JMP, 6'h00, 0, 1, E_DEC);
        add(0, JMP, 6'h00, 0, 1, E_JEX);
`ifndef MC_ILLOP_TRAP_EN
        // unknown opcode retires from DECODE as a NOP
        add(0, BAD, 6'h00, 0, 1, E_FR);
        add(0, BAD, 6'h00, 0, 1, E_DNOP);
`endif
        add(0, ADDI, 6'h00, 0, 0, E_FW);

        reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step(1, RT, 6'h00, 0, 1, E_RST, "reset_fetch");
        step(1, RT, 6'h00, 0, 1, E_RST, "reset_hold");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].rdy,
                 vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Finish the pending fetch, then abort a lb with reset in MEMRD.
        step(0, LB, 6'h00, 0, 1, E_FR,      "abort_fetch");
        step(0, LB, 6'h00, 0, 1, E_DEC,     "abort_decode");
        step(0, LB, 6'h00, 0, 1, E_MA,      "abort_memadr");
        step(0, LB, 6'h00, 0, 0, E_MRD,     "abort_memrd");
        step(1, LB, 6'h00, 0, 1, E_MRD_RST, "abort_reset_cycle");
        step(0, LB, 6'h00, 0, 0, E_FW,      "abort_back_to_fetch");

        // Retire a j so FETCH is entered with a fresh wait count, then starve it.
        step(0, JMP, 6'h00, 0, 1, E_FR,  "to_j_fetch");
        step(0, JMP, 6'h00, 0, 1, E_DEC, "to_j_decode");
        step(0, JMP, 6'h00, 0, 1, E_JEX, "to_j_exec");
        for (int i = 0; i < 16; i++) begin
            step(0, JMP, 6'h00, 0, 0, E_FW, $sformatf("stall_fetch%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            step(0, LB, 6'h00, 1, 1, E_HALT_ERR, $sformatf("halt_sticky%0d", i));
        end
        step(1, LB, 6'h00, 0, 1, E_HALT_ERR, "halt_during_reset");
        step(0, LB, 6'h00, 0, 1, E_FR,       "fetch_after_halt_reset");

`ifdef MC_ILLOP_TRAP_EN
        step(0, BAD, 6'h00, 0, 1, E_FR,  "illop_fetch");
        step(0, BAD, 6'h00, 0, 1, E_DEC, "illop_decode");
        step(0, BAD, 6'h00, 0, 1, mk(4'd12, 0,0,0,0,0, 0,0,0,0, 2'b00, 2'b00, 3'b000, 0, 0),
             "illop_halt");
        checks++;
        if (illop !== 1'b1) begin
            errors++;
            $display("FAIL illop_flag: got %b expected 1", illop);
        end
        step(1, RT, 6'h00, 0, 1, mk(4'd12, 0,0,0,0,0, 0,0,0,0, 2'b00, 2'b00, 3'b000, 0, 0),
             "illop_reset");
        checks++;
        if (illop !== 1'b0) begin
            errors++;
            $display("FAIL illop_clear: got %b expected 0", illop);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
